// File: rtl/assign2_pkg.sv
// Shared widths, ALU operation codes and the issued-instruction bundle for the assign2 pipeline.
package assign2_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;
  localparam int MEM_AW = 8;

  localparam logic [3:0] FN_ADD  = 4'd0;
  localparam logic [3:0] FN_SUB  = 4'd1;
  localparam logic [3:0] FN_MUL  = 4'd2;
  localparam logic [3:0] FN_SELA = 4'd3;
  localparam logic [3:0] FN_SELB = 4'd4;
  localparam logic [3:0] FN_AND  = 4'd5;
  localparam logic [3:0] FN_OR   = 4'd6;
  localparam logic [3:0] FN_XOR  = 4'd7;
  localparam logic [3:0] FN_NEGA = 4'd8;
  localparam logic [3:0] FN_NEGB = 4'd9;
  localparam logic [3:0] FN_SRA  = 4'd10;
  localparam logic [3:0] FN_SLA  = 4'd11;

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [3:0]        func;
    logic [MEM_AW-1:0] addr;
  } instr_t;

endpackage

// File: rtl/assign2_alu.sv
// Combinational ALU, zero latency; no handshake, result follows inputs.
module assign2_alu
  import assign2_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        func,
  output logic [DATA_W-1:0] result
);

  // Every result wraps to DATA_W bits; unused codes yield zero.
  always_comb begin
    result = '0;
    case (func)
      FN_ADD:  result = a + b;
      FN_SUB:  result = a - b;
      FN_MUL:  result = a * b;
      FN_SELA: result = a;
      FN_SELB: result = b;
      FN_AND:  result = a & b;
      FN_OR:   result = a | b;
      FN_XOR:  result = a ^ b;
      FN_NEGA: result = -a;
      FN_NEGB: result = -b;
      FN_SRA:  result = a >> 1;
      FN_SLA:  result = a << 1;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/assign2.sv
// Four-stage read/ALU/write-back/store pipeline, 3 edges from issue to Z.
// No backpressure: one instruction is accepted every cycle that rst is low.
module assign2
  import assign2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] Z,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic [3:0]        func,
  input  logic [MEM_AW-1:0] addr
);

  logic [DATA_W-1:0] regbank [0:(1<<REG_AW)-1];
  logic [DATA_W-1:0] mem     [0:(1<<MEM_AW)-1];

  instr_t            ins;

  // stage 1 -> 2
  logic              v12;
  logic [DATA_W-1:0] L12_A;
  logic [DATA_W-1:0] L12_B;
  logic [REG_AW-1:0] rd12;
  logic [3:0]        func12;
  logic [MEM_AW-1:0] addr12;

  // stage 2 -> 3
  logic              v23;
  logic [DATA_W-1:0] L23_Z;
  logic [REG_AW-1:0] rd23;
  logic [MEM_AW-1:0] addr23;

  // stage 3 -> 4
  logic              v34;
  logic [DATA_W-1:0] L34_Z;
  logic [MEM_AW-1:0] addr34;

  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] alu_z;

  assign ins = '{rs1: rs1, rs2: rs2, rd: rd, func: func, addr: addr};

  // The write-back on this same edge must be visible to the read, so bypass it.
  always_comb begin
    opa = regbank[ins.rs1];
    opb = regbank[ins.rs2];
    if (v23 && (rd23 == ins.rs1)) opa = L23_Z;
    if (v23 && (rd23 == ins.rs2)) opb = L23_Z;
  end

  assign2_alu u_alu (
    .a      (L12_A),
    .b      (L12_B),
    .func   (func12),
    .result (alu_z)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v12    <= 1'b0;
      L12_A  <= '0;
      L12_B  <= '0;
      rd12   <= '0;
      func12 <= '0;
      addr12 <= '0;
      v23    <= 1'b0;
      L23_Z  <= '0;
      rd23   <= '0;
      addr23 <= '0;
      v34    <= 1'b0;
      L34_Z  <= '0;
      addr34 <= '0;
    end else begin
      v12    <= 1'b1;
      L12_A  <= opa;
      L12_B  <= opb;
      rd12   <= ins.rd;
      func12 <= ins.func;
      addr12 <= ins.addr;

      v23    <= v12;
      L23_Z  <= alu_z;
      rd23   <= rd12;
      addr23 <= addr12;

      v34    <= v23;
      L34_Z  <= L23_Z;
      addr34 <= addr23;
    end
  end

  // Storage is never reset; rst only suppresses the writes of squashed work.
  always_ff @(posedge clk) begin
    if (!rst && v23) regbank[rd23] <= L23_Z;
  end

  always_ff @(posedge clk) begin
    if (!rst && v34) mem[addr34] <= L34_Z;
  end

  assign Z = L34_Z;

endmodule

// File: tb/tb_assign2.sv
// Directed-vector bench for assign2 with hand-computed expectations.
module tb_assign2;
  import assign2_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] Z;
  logic [REG_AW-1:0] rs1 = '0;
  logic [REG_AW-1:0] rs2 = '0;
  logic [REG_AW-1:0] rd = '0;
  logic [3:0]        func = '0;
  logic [MEM_AW-1:0] addr = '0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [3:0]  func;
    logic [7:0]  addr;
    logic [15:0] z;
  } vec_t;

  vec_t prog[$];
  vec_t filler;

  assign2 dut (
    .clk  (clk),
    .rst  (rst),
    .Z    (Z),
    .rs1  (rs1),
    .rs2  (rs2),
    .rd   (rd),
    .func (func),
    .addr (addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(input int a, input int b, input int d, input logic [3:0] f,
                              input int ad, input int z);
    vec_t v;
    v.rs1 = 4'(a); v.rs2 = 4'(b); v.rd = 4'(d); v.func = f;
    v.addr = 8'(ad); v.z = 16'(z);
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input vec_t v);
    rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; func = v.func; addr = v.addr;
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    tick;
    tick;
    check({name, "_rst_z"}, 32'(Z), 32'h0);
  endtask

  task automatic preload_k;
    for (int k = 0; k < 16; k++) dut.regbank[k] = 16'(k);
  endtask

  // Streams prog back to back from the first cycle after reset, then drains.
  task automatic run_prog(input string name);
    int n;
    n = prog.size();
    rst = 1'b0;
    for (int c = 0; c < n + 3; c++) begin
      if (c < n) issue(prog[c]);
      else       issue(filler);
      tick;
      if (c == 0) check($sformatf("%s_z_first", name), 32'(Z), 32'h0);
      if (c >= 2 && (c - 2) < n)
        check($sformatf("%s_z%0d", name, c - 2), 32'(Z), 32'(prog[c-2].z));
    end
    rst = 1'b1;
    tick;
  endtask

  initial begin
    filler = mk(0, 0, 11, 4'd12, 0, 0);

    // Main stream with regbank[k] = k
    do_reset("main");
    preload_k;
    prog.delete();
    prog.push_back(mk(3, 5, 10, FN_ADD, 125, 8));
    prog.push_back(mk(3, 8, 12, FN_MUL, 126, 24));
    prog.push_back(mk(10, 5, 14, FN_SUB, 128, 3));
    prog.push_back(mk(7, 0, 13, FN_SLA, 127, 14));
    prog.push_back(mk(10, 5, 15, FN_SUB, 129, 3));
    prog.push_back(mk(12, 13, 0, FN_ADD, 130, 38));
    run_prog("main");
    check("main_r10", 32'(dut.regbank[10]), 32'd8);
    check("main_r12", 32'(dut.regbank[12]), 32'd24);
    check("main_r14", 32'(dut.regbank[14]), 32'd3);
    check("main_r13", 32'(dut.regbank[13]), 32'd14);
    check("main_r15", 32'(dut.regbank[15]), 32'd3);
    check("main_r0",  32'(dut.regbank[0]),  32'd38);
    check("main_m125", 32'(dut.mem[125]), 32'd8);
    check("main_m126", 32'(dut.mem[126]), 32'd24);
    check("main_m127", 32'(dut.mem[127]), 32'd14);
    check("main_m128", 32'(dut.mem[128]), 32'd3);
    check("main_m129", 32'(dut.mem[129]), 32'd3);
    check("main_m130", 32'(dut.mem[130]), 32'd38);

    // Distance-1 hazard reads the stale register
    do_reset("haz");
    preload_k;
    prog.delete();
    prog.push_back(mk(1, 2, 5, FN_ADD, 50, 3));
    prog.push_back(mk(5, 5, 6, FN_ADD, 51, 10));
    run_prog("haz");
    check("haz_r5", 32'(dut.regbank[5]), 32'd3);
    check("haz_r6", 32'(dut.regbank[6]), 32'd10);
    check("haz_m51", 32'(dut.mem[51]), 32'd10);

    // Every func code with A=0x8001, B=0x0003
    do_reset("alu");
    preload_k;
    dut.regbank[1] = 16'h8001;
    dut.regbank[2] = 16'h0003;
    prog.delete();
    prog.push_back(mk(1, 2, 3,  FN_ADD,  10, 'h8004));
    prog.push_back(mk(2, 1, 4,  FN_SUB,  11, 'h8002));
    prog.push_back(mk(1, 2, 5,  FN_MUL,  12, 'h8003));
    prog.push_back(mk(1, 2, 6,  FN_SELA, 13, 'h8001));
    prog.push_back(mk(1, 2, 7,  FN_SELB, 14, 'h0003));
    prog.push_back(mk(1, 2, 8,  FN_AND,  15, 'h0001));
    prog.push_back(mk(1, 2, 9,  FN_OR,   16, 'h8003));
    prog.push_back(mk(1, 2, 10, FN_XOR,  17, 'h8002));
    prog.push_back(mk(1, 2, 12, FN_NEGA, 18, 'h7FFF));
    prog.push_back(mk(1, 2, 13, FN_NEGB, 19, 'hFFFD));
    prog.push_back(mk(1, 2, 14, FN_SRA,  20, 'h4000));
    prog.push_back(mk(1, 2, 15, FN_SLA,  21, 'h0002));
    prog.push_back(mk(1, 2, 0,  4'd12,   22, 'h0000));
    run_prog("alu");
    check("alu_r12_nega", 32'(dut.regbank[12]), 32'h7FFF);
    check("alu_m21_sla",  32'(dut.mem[21]),     32'h0002);

    // Reset with three instructions in flight
    do_reset("squash");
    preload_k;
    dut.mem[200] = 16'hDEAD;
    dut.mem[201] = 16'hBEEF;
    dut.mem[202] = 16'hCAFE;
    dut.mem[203] = 16'h1111;
    rst = 1'b0;
    issue(mk(1, 2, 4, FN_ADD, 200, 3)); tick;
    issue(mk(3, 3, 5, FN_ADD, 201, 6)); tick;
    issue(mk(4, 4, 6, FN_ADD, 202, 6)); tick;
    rst = 1'b1;
    tick;
    check("squash_z_in_rst", 32'(Z), 32'h0);
    tick;
    tick;
    check("squash_r4", 32'(dut.regbank[4]), 32'd3);
    check("squash_r5", 32'(dut.regbank[5]), 32'd5);
    check("squash_r6", 32'(dut.regbank[6]), 32'd6);
    check("squash_m200", 32'(dut.mem[200]), 32'hDEAD);
    check("squash_m201", 32'(dut.mem[201]), 32'hBEEF);
    check("squash_m202", 32'(dut.mem[202]), 32'hCAFE);
    issue(mk(1, 1, 7, FN_ADD, 203, 2));
    rst = 1'b0;
    tick;
    check("resume_z_first", 32'(Z), 32'h0);
    issue(filler);
    tick;
    tick;
    check("resume_z", 32'(Z), 32'd2);
    tick;
    rst = 1'b1;
    tick;
    check("resume_r7", 32'(dut.regbank[7]), 32'd2);
    check("resume_m203", 32'(dut.mem[203]), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/assign2.md
Name: assign2

Overview:
- Four-stage arithmetic pipeline: register read, ALU, register write-back, memory store.
- Contains a 16x16 register bank and a 256x16 data memory.
- One instruction (rs1, rs2, rd, func, addr) is accepted every clock.
- The result is written to regbank[rd] and then to mem[addr]; the stage-3 result is exported on Z.

Parameters:
- DATA_W, 16, width of registers, memory words, ALU result and Z.
- REG_AW, 4, register-bank address width (16 entries).
- MEM_AW, 8, data-memory address width (256 entries).

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- Z  out  DATA_W  stage-3 result register (L34_Z).
- rs1  in  REG_AW  source A register index.
- rs2  in  REG_AW  source B register index.
- rd  in  REG_AW  destination register index.
- func  in  4  ALU operation code.
- addr  in  MEM_AW  memory store address.

Behaviour:
- Storage arrays are named regbank[0:15] and mem[0:255] and must be directly writable and readable by the bench hierarchically.
- rst clears all pipeline registers and valid bits; Z=0 while in reset and on the first cycle after. regbank and mem are NOT reset; the bench preloads regbank.
- Mid-operation reset squashes all in-flight instructions; no regbank or mem write occurs on the cycle rst is high.
- Every cycle with rst=0 issues a valid instruction. There is no stall and no input handshake.
- Stage 1 (edge n):
  - Latch L12_A=regbank[rs1], L12_B=regbank[rs2], plus rd, func, addr, and valid.
  - Write-through: if stage 3 writes register r on the same edge, a read of r returns the new value.
  - With write-through, an instruction issued 2 or more cycles after its producer sees the produced value.
  - Back-to-back issue (distance 1) reads the stale value. There is no interlock or forwarding for that case.
- Stage 2 (edge n+1): L23_Z = ALU(A,B,func), truncated to DATA_W. rd, addr and valid are forwarded.
- ALU func codes:
  - 0 A+B; 1 A-B; 2 A*B (low 16 bits).
  - 3 A; 4 B.
  - 5 A&B; 6 A|B; 7 A^B.
  - 8 -A; 9 -B (two's complement).
  - 10 A>>1 (logical); 11 A<<1.
  - 12-15 produce 0.
- Stage 3 (edge n+2): if valid, regbank[rd] <= L23_Z. L34_Z <= L23_Z, and addr and valid are forwarded. Z = L34_Z, so latency from issue to Z is 3 edges.
- Stage 4 (edge n+3): if valid, mem[addr] <= L34_Z.
- Register 0 is an ordinary writable register.
- Arithmetic wraps modulo 2^16 with no flags.
- Index inputs are exactly REG_AW wide; an index of 16 applied by a bench truncates to 0.

Decomposition:
- Package assign2_pkg: DATA_W, REG_AW, MEM_AW and the func code localparams (FN_ADD..FN_SLA).
- Sub-module assign2_alu: combinational; inputs A, B, func; output result.
- Register bank, memory and pipeline registers stay in the top module.

Test Plan:
- Preload regbank[k]=k. Issue one instruction per clock from the first cycle after reset, in this order:
  1. ADD 3,5->R10 @125
  2. MUL 3,8->R12 @126
  3. SUB 10,5->R14 @128
  4. SLA 7->R13 @127
  5. SUB 10,5->R15 @129
  6. ADD 12,13->R0 @130
- Required register results: R10=8, R12=24, R14=3, R13=14, R15=3, R0=38.
- Required memory results: mem[125..130] = 8, 24, 14, 3, 3, 38.
- Z sequence for that stream: 8, 24, 3, 14, 3, 38 on consecutive cycles, starting 3 edges after the first issue.
- Hazard at distance 1: ADD 1,2->R5, then immediately ADD 5,5->R6. Required: R6=10 (stale R5=5), R5=3.
- Each remaining func with A=0x8001, B=0x0003:
  - SELA 0x8001, SELB 0x0003.
  - AND 0x0001, OR 0x8003, XOR 0x8002.
  - NEGA 0x7FFF, SRA 0x4000, SLA 0x0002.
  - func 12 gives 0.
  - SUB 3-0x8001 gives 0x8002.
- Assert rst while 3 instructions are in flight. Required: no regbank or mem change after the reset edge, Z=0, and the pipeline resumes cleanly on the next issue.
